mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between several requesters. Requesters are the processor's program-fetch port, its data port, and a debug/loader port.
- Sits between the multicycle processor core and the unified program/data RAM.
- Sequences each access with a small FSM and round-robin arbitration, and routes the read response back to the requester that owns the access.

Parameters:
- NREQ, 3, number of requesters; index 0 = fetch, 1 = data, 2 = debug. Legal range 1..8.
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata. Must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester access request.
- req_we  in  NREQ  per-requester write enable (1 = write, 0 = read).
- req_addr  in  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; requester i occupies [i*DW +: DW].
- req_ready  out  NREQ  one-hot; the request is accepted in this cycle.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse; read data is valid for that requester.
- rsp_rdata  out  DW  read data, shared by all requesters.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high while a read is outstanding.
- owner  out  3  index of the current or last granted requester.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, rr_ptr = 0, owner = 0, wait counter = 0.
  - req_ready, rsp_valid, mem_en, mem_we and busy are all 0.
  - rsp_rdata, mem_addr and mem_wdata are 0.
- States: IDLE, WAIT, RESP.
- IDLE with no req_valid bits set:
  - All strobes are 0.
  - mem_addr and mem_wdata hold their last values.
- IDLE with any req_valid set (grant cycle):
  - Winner g = first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - In the same cycle, combinationally: req_ready[g] = 1, mem_en = 1, mem_we = req_we[g], mem_addr and mem_wdata are driven from requester g's fields.
  - At the clock edge: owner <= g; rr_ptr <= (g+1) mod NREQ.
  - Write grant: the write completes at that edge; next state is IDLE; no response is generated. Back-to-back writes therefore sustain one per cycle.
  - Read grant: next state is WAIT with counter = MEM_LAT-1.
- WAIT:
  - busy = 1; no grants are issued; mem_en = 0.
  - The counter decrements each cycle; when it reaches 0, next state is RESP.
  - With MEM_LAT = 1, WAIT lasts exactly one cycle.
- RESP:
  - rsp_valid[owner] = 1 for exactly one cycle; rsp_rdata = mem_rdata, registered, so it stays stable after the pulse until the next read response.
  - A new grant may be issued in the same cycle (IDLE grant logic is also active in RESP), so a read costs MEM_LAT+1 cycles of port occupancy.
- Latency:
  - Read: grant cycle to rsp_valid = MEM_LAT+1 cycles.
  - Write: 0 cycles after the grant.
- Requester rules:
  - Hold req_valid, req_we, req_addr and req_wdata stable until req_ready is seen.
  - Dropping req_valid before the grant withdraws the request with no side effects.
  - Responses cannot be backpressured; requesters must capture them.
- Simultaneous requests: the round-robin order guarantees each active requester is granted within NREQ grants (no starvation).
- req_valid bits at indices >= NREQ do not exist. With NREQ = 1, requester 0 is always the winner.
- Reset asserted mid-read: the access is abandoned, no rsp_valid is issued, and the FSM restarts in IDLE.
- owner is 3 bits wide, sufficient for NREQ up to 8.

Decomposition:
- Shared package or header holds:
  - state encodings: ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2;
  - requester index constants: REQ_FETCH = 0, REQ_DATA = 1, REQ_DEBUG = 2.
- One sub-module, rr_picker: combinational round-robin search.
  - Inputs: req_valid vector and rr_ptr.
  - Outputs: one-hot grant and the grant index.
  - Reusable by other bus arbiters in the design.

Test Plan:
- Reset: hold reset low for 3 cycles with req_valid = 3'b111 -> req_ready = 0 and mem_en = 0 throughout; after release, the first grant goes to requester 0.
- Single read, MEM_LAT = 1: requester 1 reads address 0x0000_0010; memory returns 0xDEAD_BEEF -> req_ready = 3'b010 in cycle T; rsp_valid = 3'b010 in T+2 with rsp_rdata = 0xDEAD_BEEF; busy is high in T+1.
- Back-to-back writes: requester 2 writes 0x20, 0x24 and 0x28 on consecutive cycles with no other requester active -> mem_en = 1 for three consecutive cycles with matching addresses and data; rsp_valid stays 0.
- Fairness: req_valid held at 3'b111 with all requests reads -> grant order 0,1,2,0,1,2; each requester is granted once per 3 grants.
- Reset mid-read with MEM_LAT = 3: assert reset during WAIT -> no rsp_valid pulse; after release the next request is granted normally.
- Request withdrawal: requester 0 raises then drops req_valid in a cycle where requester 1 is granted -> no access to requester 0's address occurs.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and requester indices.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_DEBUG = 2;

  localparam int OWNER_W = 3;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin search: lowest requesting index at or above ptr,
// wrapping to the lowest requesting index overall. Reusable by other bus arbiters.
module rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]       req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [N-1:0]       grant,
  output logic [OWNER_W-1:0] idx,
  output logic               any
);

  logic [N-1:0] upper;
  logic [N-1:0] src;

  always_comb begin
    upper = '0;
    for (int j = 0; j < N; j++) begin
      upper[j] = req[j] && (OWNER_W'(j) >= ptr);
    end
    // Prefer requesters at or above the pointer; otherwise wrap around.
    src   = (|upper) ? upper : req;
    grant = src & (~src + 1'b1);
    idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (src[j]) idx = OWNER_W'(j);
    end
    any = |req;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between fetch, data and debug ports,
// with round-robin arbitration and response routing back to the owning requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic               busy,
  output logic [2:0]         owner,
  output logic [1:0]         dbg_state
);

  // Handshake: a requester holds req_valid and its fields stable until it sees
  // req_ready[i] high in a cycle; that cycle is the transfer. Dropping req_valid
  // before then withdraws the request. rsp_valid is a one-cycle pulse with no
  // backpressure, so requesters must capture rsp_rdata when it is seen.

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    rr_ptr, rr_ptr_n;
  logic [2:0]    owner_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic [NREQ-1:0] pick_oh;
  logic [2:0]      pick_idx;
  logic            pick_any;
  logic            grant;
  logic            grant_we;

  rr_picker #(.N(NREQ)) u_rr_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // RESP also grants, so a read occupies the port for MEM_LAT+1 cycles.
  always_comb begin
    grant    = reset && pick_any && (state == ST_IDLE || state == ST_RESP);
    grant_we = |(req_we & pick_oh);
    rr_ptr_n = (pick_idx == 3'(NREQ - 1)) ? 3'd0 : pick_idx + 3'd1;
  end

  always_comb begin
    req_ready = grant ? pick_oh : '0;
    mem_en    = grant;
    mem_we    = grant && grant_we;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (grant) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pick_oh[i]) begin
          mem_addr  = req_addr[i*AW +: AW];
          mem_wdata = req_wdata[i*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state == ST_RESP) && (owner_q == 3'(i));
    end
    rsp_rdata = rdata_q;
    busy      = (state == ST_WAIT);
    owner     = owner_q;
    dbg_state = state;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE, ST_RESP: begin
        state_n = ST_IDLE;
        if (grant && !grant_we) begin
          state_n = ST_WAIT;
          cnt_n   = CW'(MEM_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_n = ST_RESP;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rr_ptr  <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (grant) begin
        owner_q <= pick_idx;
        rr_ptr  <= rr_ptr_n;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      // Last WAIT cycle is the one where the RAM output carries this read.
      if (state == ST_WAIT && cnt == '0) rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 with a read
// scoreboard, one at MEM_LAT=3 for the reset-during-WAIT case.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int EW = 51;  // {stamp[15:0], idx[2:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic [2:0]  req_valid, req_we;
  logic [95:0] req_addr, req_wdata;

  // ---------------- DUT at MEM_LAT = 1 ----------------
  logic [2:0]  ready1, rsp_valid1, owner1;
  logic [31:0] rdata1, addr1, wdata1, mem_rdata1;
  logic        mem_en1, mem_we1, busy1;
  logic [1:0]  dbg1;

  mem_port_arbiter #(.NREQ(3), .AW(32), .DW(32), .MEM_LAT(1)) dut (
    .clk(clk), .reset(rst1),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(ready1), .rsp_valid(rsp_valid1), .rsp_rdata(rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1), .dbg_state(dbg1)
  );

  // ---------------- DUT at MEM_LAT = 3 ----------------
  logic [2:0]  ready3, rsp_valid3, owner3;
  logic [31:0] rdata3, addr3, wdata3, mem_rdata3;
  logic        mem_en3, mem_we3, busy3;
  logic [1:0]  dbg3;

  mem_port_arbiter #(.NREQ(3), .AW(32), .DW(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(rst3),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(ready3), .rsp_valid(rsp_valid3), .rsp_rdata(rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(addr3), .mem_wdata(wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .owner(owner3), .dbg_state(dbg3)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] rom_val(input logic [31:0] a);
    return a ^ 32'hDEAD_BEFF;
  endfunction

  logic [31:0] rd1, p0, p1, p2;
  always @(posedge clk) begin
    rd1 <= mem_en1 ? rom_val(addr1) : 32'h0BAD_0BAD;
    p0  <= mem_en3 ? rom_val(addr3) : 32'h0BAD_0BAD;
    p1  <= p0;
    p2  <= p1;
  end
  assign mem_rdata1 = rd1;
  assign mem_rdata3 = p2;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  // ---------------- scoreboard (MEM_LAT = 1 instance) ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (rst1) begin
      if (ready1 != 3'b000 && (ready1 & req_we) == 3'b000) begin
        for (int i = 0; i < 3; i++) begin
          if (ready1[i]) exp_q.push_back({cyc[15:0], 3'(i), rom_val(req_addr[i*32 +: 32])});
        end
      end
      if (rsp_valid1 != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("rsp_spurious", {61'd0, rsp_valid1}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_owner", {61'd0, rsp_valid1}, 64'd1 << e[34:32]);
          check("rsp_rdata", {32'd0, rdata1}, {32'd0, e[31:0]});
          check("rsp_latency", {48'd0, cyc[15:0]}, {48'd0, e[50:35] + 16'd2});
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  int k;
  int last;

  initial begin
    rst1 = 1'b0; rst3 = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    k = 0; last = 0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0);

    // Reset held with every requester asking.
    mid();
    check("rst_busy", {63'd0, busy1}, 64'd0);
    check("rst_rsp_valid", {61'd0, rsp_valid1}, 64'd0);
    check("rst_owner", {61'd0, owner1}, 64'd0);
    check("rst_mem_addr", {32'd0, addr1}, 64'd0);
    check("rst_mem_wdata", {32'd0, wdata1}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rdata1}, 64'd0);
    check("rst_state", {62'd0, dbg1}, {62'd0, ST_IDLE});
    for (int c = 0; c < 3; c++) begin
      mid();
      check("rst_ready", {61'd0, ready1}, 64'd0);
      check("rst_mem_en", {63'd0, mem_en1}, 64'd0);
      check("rst_mem_we", {63'd0, mem_we1}, 64'd0);
      nxt();
    end
    rst1 = 1'b1;
    mid();
    check("first_grant", {61'd0, ready1}, 64'b001);
    check("first_mem_en", {63'd0, mem_en1}, 64'd1);
    check("first_addr", {32'd0, addr1}, 64'h100);
    nxt();
    req_valid = '0;
    mid();
    check("first_state_wait", {62'd0, dbg1}, {62'd0, ST_WAIT});
    nxt();
    mid();
    check("first_state_resp", {62'd0, dbg1}, {62'd0, ST_RESP});
    nxt();
    nxt();

    // Single read by the data port.
    set_req(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    mid();
    check("rd_ready", {61'd0, ready1}, 64'b010);
    check("rd_mem_en", {63'd0, mem_en1}, 64'd1);
    check("rd_mem_we", {63'd0, mem_we1}, 64'd0);
    check("rd_mem_addr", {32'd0, addr1}, 64'h10);
    nxt();
    req_valid = '0;
    mid();
    check("rd_busy", {63'd0, busy1}, 64'd1);
    check("rd_wait_mem_en", {63'd0, mem_en1}, 64'd0);
    check("rd_wait_rsp", {61'd0, rsp_valid1}, 64'd0);
    nxt();
    mid();
    check("rd_rsp_valid", {61'd0, rsp_valid1}, 64'b010);
    check("rd_rsp_data", {32'd0, rdata1}, 64'hDEAD_BEEF);
    check("rd_resp_busy", {63'd0, busy1}, 64'd0);
    check("rd_owner", {61'd0, owner1}, 64'd1);
    nxt();
    mid();
    check("rd_rsp_pulse", {61'd0, rsp_valid1}, 64'd0);
    check("rd_rsp_hold", {32'd0, rdata1}, 64'hDEAD_BEEF);
    nxt();

    // Back-to-back writes from the debug port.
    for (int w = 0; w < 3; w++) begin
      set_req(2, 1'b1, 1'b1, 32'h20 + 32'(w * 4), 32'hC0DE_0000 + 32'(w));
      mid();
      check("wr_ready", {61'd0, ready1}, 64'b100);
      check("wr_mem_en", {63'd0, mem_en1}, 64'd1);
      check("wr_mem_we", {63'd0, mem_we1}, 64'd1);
      check("wr_mem_addr", {32'd0, addr1}, 64'h20 + 64'(w * 4));
      check("wr_mem_wdata", {32'd0, wdata1}, 64'hC0DE_0000 + 64'(w));
      check("wr_no_rsp", {61'd0, rsp_valid1}, 64'd0);
      nxt();
    end
    req_valid = '0;
    mid();
    check("wr_idle_en", {63'd0, mem_en1}, 64'd0);
    check("wr_idle_addr_hold", {32'd0, addr1}, 64'h28);
    check("wr_idle_wdata_hold", {32'd0, wdata1}, 64'hC0DE_0002);
    check("wr_idle_no_rsp", {61'd0, rsp_valid1}, 64'd0);
    nxt();

    // Fairness: every requester reading continuously.
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
    for (int n = 0; n < 40 && k < 6; n++) begin
      mid();
      if (ready1 != 3'b000) begin
        check("fair_grant", {61'd0, ready1}, 64'd1 << (k % 3));
        if (k > 0) check("fair_spacing", 64'(cyc - last), 64'd2);
        last = cyc;
        k++;
      end
      nxt();
    end
    req_valid = '0;
    check("fair_count", 64'(k), 64'd6);
    repeat (4) nxt();

    // Withdrawal: fetch port raises and drops while the data port is granted.
    set_req(0, 1'b1, 1'b1, 32'h30, 32'h1111);
    mid();
    check("wd_pre_ready", {61'd0, ready1}, 64'b001);
    nxt();
    req_valid = '0;
    set_req(0, 1'b1, 1'b0, 32'h80, 32'h0);
    set_req(1, 1'b1, 1'b1, 32'h40, 32'h2222);
    mid();
    check("wd_ready", {61'd0, ready1}, 64'b010);
    check("wd_mem_addr", {32'd0, addr1}, 64'h40);
    check("wd_mem_we", {63'd0, mem_we1}, 64'd1);
    nxt();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      mid();
      check("wd_no_access", {63'd0, mem_en1}, 64'd0);
      check("wd_addr_hold", {32'd0, addr1}, 64'h40);
      nxt();
    end
    mid();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    nxt();

    // MEM_LAT = 3: reset during WAIT abandons the read.
    rst1 = 1'b0;
    rst3 = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h50, 32'h0);
    mid();
    check("l3_ready", {61'd0, ready3}, 64'b001);
    check("l3_mem_en", {63'd0, mem_en3}, 64'd1);
    check("l3_mem_addr", {32'd0, addr3}, 64'h50);
    nxt();
    req_valid = '0;
    mid();
    check("l3_busy", {63'd0, busy3}, 64'd1);
    check("l3_state_wait", {62'd0, dbg3}, {62'd0, ST_WAIT});
    nxt();
    rst3 = 1'b0;
    mid();
    check("l3_rst_busy", {63'd0, busy3}, 64'd0);
    check("l3_rst_state", {62'd0, dbg3}, {62'd0, ST_IDLE});
    check("l3_rst_rsp", {61'd0, rsp_valid3}, 64'd0);
    for (int c = 0; c < 2; c++) begin
      nxt();
      mid();
      check("l3_rst_hold_rsp", {61'd0, rsp_valid3}, 64'd0);
    end
    nxt();
    rst3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mid();
      check("l3_abandoned_rsp", {61'd0, rsp_valid3}, 64'd0);
      check("l3_abandoned_busy", {63'd0, busy3}, 64'd0);
      nxt();
    end
    set_req(2, 1'b1, 1'b0, 32'h60, 32'h0);
    mid();
    check("l3_regrant", {61'd0, ready3}, 64'b100);
    check("l3_regrant_addr", {32'd0, addr3}, 64'h60);
    nxt();
    req_valid = '0;
    for (int t = 1; t <= 3; t++) begin
      mid();
      check("l3_wait_busy", {63'd0, busy3}, 64'd1);
      check("l3_wait_rsp", {61'd0, rsp_valid3}, 64'd0);
      nxt();
    end
    mid();
    check("l3_rsp_valid", {61'd0, rsp_valid3}, 64'b100);
    check("l3_rsp_data", {32'd0, rdata3}, {32'd0, rom_val(32'h60)});
    check("l3_owner", {61'd0, owner3}, 64'd2);
    nxt();
    mid();
    check("l3_rsp_pulse", {61'd0, rsp_valid3}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
